// File: rtl/vmode_sequencer_if.sv
// Register-write bus between a CPU-side requester, the video-mode sequencer
// and the beam counter's register file.
//   cpu_req / cpu_addr / cpu_data : one pending CPU register write, held until cpu_ack
//   cpu_ack                       : one-cycle acknowledge of the CPU write
//   reg_address_out / data_out    : register write address (word offset, bits 8:1) and data
//   reg_we                        : one-cycle write strobe toward the beam counter
// Modports: master = CPU side plus beam-counter observer, slave = sequencer.
interface vmode_sequencer_if;
   logic        cpu_req;
   logic [8:1]  cpu_addr;
   logic [15:0] cpu_data;
   logic        cpu_ack;
   logic [8:1]  reg_address_out;
   logic [15:0] data_out;
   logic        reg_we;

   modport master (
      output cpu_req, cpu_addr, cpu_data,
      input  cpu_ack, reg_address_out, data_out, reg_we
   );

   modport slave (
      input  cpu_req, cpu_addr, cpu_data,
      output cpu_ack, reg_address_out, data_out, reg_we
   );
endinterface

// File: rtl/vmode_sequencer.sv
// Video-mode sequencer: on start, waits for end of frame and then writes a
// short table of beam-counter registers (one per clk7_en slot) for the chosen
// mode. In idle it forwards CPU register writes onto the same bus.
// Ports:
//   clk, reset       : 28 MHz clock, synchronous active-high reset
//   clk7_en          : one-in-four write slot enable
//   eof              : end-of-frame pulse, qualified by clk7_en
//   start, mode_sel  : load request and mode (0 PAL15k, 1 NTSC15k, 2 31k/525, 3 31k/625)
//   busy, done       : load pending/running, one-cycle load-complete pulse
//   bus              : CPU write request and register write bus (slave side)
//
// state    | meaning
// IDLE     | no load; CPU writes forwarded on clk7_en slots
// WAIT_EOF | mode latched, waiting for clk7_en & eof
// WRITE    | one table entry per clk7_en slot
// FINISH   | pulse done, drop busy, back to IDLE
module vmode_sequencer (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk7_en,
   input  logic             eof,
   input  logic             start,
   input  logic [1:0]       mode_sel,
   output logic             busy,
   output logic             done,
   vmode_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WAIT_EOF, WRITE, FINISH} state_t;

   state_t      state_q, state_d;
   logic [1:0]  mode_q, mode_d;
   logic [2:0]  idx_q, idx_d;
   logic        busy_d, done_d, ack_d, we_d;
   logic [8:1]  addr_d;
   logic [15:0] data_d;

   logic [8:1]  tbl_addr;
   logic [15:0] tbl_data;
   logic [15:0] beamcon0;
   logic        tbl_last;

   // Table entry for the current index. 15 kHz modes only touch BEAMCON0,
   // so their table is a single entry at index 0.
   always_comb begin
      case (mode_q)
         2'd0:    beamcon0 = 16'h0020;
         2'd1:    beamcon0 = 16'h0000;
         2'd2:    beamcon0 = 16'h1B88;
         default: beamcon0 = 16'h1BA8;
      endcase
      tbl_addr = 8'hEE;
      tbl_data = beamcon0;
      tbl_last = 1'b1;
      if (mode_q[1]) begin
         tbl_last = 1'b0;
         case (idx_q)
            3'd0: begin tbl_addr = 8'hE0; tbl_data = 16'h0071; end
            3'd1: begin tbl_addr = 8'hE1; tbl_data = 16'h000C; end
            3'd2: begin
               tbl_addr = 8'hE4;
               tbl_data = mode_q[0] ? 16'h0270 : 16'h020C;
            end
            3'd3: begin tbl_addr = 8'hE5; tbl_data = 16'h0005; end
            default: begin
               tbl_addr = 8'hEE;
               tbl_data = beamcon0;
               tbl_last = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      idx_d   = idx_q;
      busy_d  = busy;
      done_d  = 1'b0;
      ack_d   = 1'b0;
      we_d    = 1'b0;
      addr_d  = '0;
      data_d  = '0;
      case (state_q)
         IDLE: begin
            // CPU write and load acceptance are independent in the same cycle.
            if (bus.cpu_req && clk7_en) begin
               we_d   = 1'b1;
               ack_d  = 1'b1;
               addr_d = bus.cpu_addr;
               data_d = bus.cpu_data;
            end
            if (start) begin
               mode_d  = mode_sel;
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = WAIT_EOF;
            end
         end
         WAIT_EOF: begin
            if (clk7_en && eof)
               state_d = WRITE;
         end
         WRITE: begin
            if (clk7_en) begin
               we_d   = 1'b1;
               addr_d = tbl_addr;
               data_d = tbl_data;
               idx_d  = idx_q + 3'd1;
               if (tbl_last)
                  state_d = FINISH;
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            idx_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q             <= IDLE;
         mode_q              <= '0;
         idx_q               <= '0;
         busy                <= 1'b0;
         done                <= 1'b0;
         bus.cpu_ack         <= 1'b0;
         bus.reg_we          <= 1'b0;
         bus.reg_address_out <= '0;
         bus.data_out        <= '0;
      end else begin
         state_q             <= state_d;
         mode_q              <= mode_d;
         idx_q               <= idx_d;
         busy                <= busy_d;
         done                <= done_d;
         bus.cpu_ack         <= ack_d;
         bus.reg_we          <= we_d;
         bus.reg_address_out <= addr_d;
         bus.data_out        <= data_d;
      end
   end

endmodule
